// File: rtl/signature_sign_if.sv
// rtl/signature_sign_if.sv - hash/key request and signature response bundle for signature_sign
interface signature_sign_if;
    logic [255:0] hash;
    logic [255:0] key;
    logic         key_valid;
    logic         sign_start;
    logic [255:0] signature;
    logic         sign_busy;
    logic         sign_done;
    logic         sign_error;

    modport master (
        output hash, key, key_valid, sign_start,
        input  signature, sign_busy, sign_done, sign_error
    );

    modport slave (
        input  hash, key, key_valid, sign_start,
        output signature, sign_busy, sign_done, sign_error
    );
endinterface

// File: rtl/signature_sign.sv
// rtl/signature_sign.sv - iterative ARX keyed signature engine, one round per clock
module signature_sign #(
    parameter int ROUNDS = 16,
    parameter int ROT    = 7
) (
    input  logic           clk,
    input  logic           reset,
    signature_sign_if.slave sig_if
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    state_t       state, state_nx;
    logic [255:0] s_q, s_nx;
    logic [255:0] key_q, key_nx;
    logic [255:0] sig_q, sig_nx;
    logic [7:0]   r_q, r_nx;
    logic         busy_q, busy_nx;
    logic         done_q, done_nx;
    logic         err_q, err_nx;
    logic [255:0] round_out;

    // Each word mixes with its upper neighbour (w7 wraps to w0), all from the old state.
    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_word
            logic [31:0] sum;
            assign sum = s_q[i*32 +: 32] + s_q[((i + 1) % 8)*32 +: 32];
            assign round_out[i*32 +: 32] = ((sum << ROT) | (sum >> (32 - ROT)))
                                           ^ key_q[i*32 +: 32] ^ {24'b0, r_q};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            s_q    <= '0;
            key_q  <= '0;
            sig_q  <= '0;
            r_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            s_q    <= s_nx;
            key_q  <= key_nx;
            sig_q  <= sig_nx;
            r_q    <= r_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
            err_q  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_nx     = s_q;
        key_nx   = key_q;
        sig_nx   = sig_q;
        r_nx     = r_q;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (sig_if.sign_start) begin
                    if (sig_if.key_valid) begin
                        key_nx   = sig_if.key;
                        s_nx     = sig_if.hash ^ sig_if.key;
                        r_nx     = '0;
                        busy_nx  = 1'b1;
                        state_nx = RUN;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                // Inputs are ignored here; only the latched key feeds the rounds.
                s_nx = round_out;
                r_nx = r_q + 8'd1;
                if (r_q == LAST_ROUND) begin
                    sig_nx   = round_out ^ key_q;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign sig_if.signature  = sig_q;
    assign sig_if.sign_busy  = busy_q;
    assign sig_if.sign_done  = done_q;
    assign sig_if.sign_error = err_q;
endmodule

// File: tb/tb_signature_sign.sv
// tb/tb_signature_sign.sv - scoreboard bench for signature_sign at ROUNDS 1, 2, 3 and 16
module tb_signature_sign;
    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] hash, key;
    logic         key_valid;
    logic [3:0]   start;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    signature_sign_if if1 ();
    signature_sign_if if2 ();
    signature_sign_if if3 ();
    signature_sign_if if16 ();

    assign if1.hash  = hash; assign if1.key  = key; assign if1.key_valid  = key_valid; assign if1.sign_start  = start[0];
    assign if2.hash  = hash; assign if2.key  = key; assign if2.key_valid  = key_valid; assign if2.sign_start  = start[1];
    assign if3.hash  = hash; assign if3.key  = key; assign if3.key_valid  = key_valid; assign if3.sign_start  = start[2];
    assign if16.hash = hash; assign if16.key = key; assign if16.key_valid = key_valid; assign if16.sign_start = start[3];

    signature_sign #(.ROUNDS(1))  u_r1  (.clk(clk), .reset(reset), .sig_if(if1.slave));
    signature_sign #(.ROUNDS(2))  u_r2  (.clk(clk), .reset(reset), .sig_if(if2.slave));
    signature_sign #(.ROUNDS(3))  u_r3  (.clk(clk), .reset(reset), .sig_if(if3.slave));
    signature_sign #(.ROUNDS(16)) u_r16 (.clk(clk), .reset(reset), .sig_if(if16.slave));

    logic [3:0]   done_v, err_v, busy_v;
    logic [255:0] sig_v [4];
    assign done_v = {if16.sign_done, if3.sign_done, if2.sign_done, if1.sign_done};
    assign err_v  = {if16.sign_error, if3.sign_error, if2.sign_error, if1.sign_error};
    assign busy_v = {if16.sign_busy, if3.sign_busy, if2.sign_busy, if1.sign_busy};
    assign sig_v[0] = if1.signature;
    assign sig_v[1] = if2.signature;
    assign sig_v[2] = if3.signature;
    assign sig_v[3] = if16.signature;

    typedef struct {
        int           id;
        bit           is_err;
        logic [255:0] sig;
        int           cyc;
    } exp_t;
    exp_t q[$];

    function automatic int rnd_of(input int id);
        case (id)
            0: return 1;
            1: return 2;
            2: return 3;
            default: return 16;
        endcase
    endfunction

    function automatic logic [255:0] ref_sign(input logic [255:0] h, input logic [255:0] k, input int rounds);
        logic [255:0] s, n;
        logic [31:0]  a;
        s = h ^ k;
        for (int r = 0; r < rounds; r++) begin
            for (int w = 0; w < 8; w++) begin
                a = s[w*32 +: 32] + s[((w + 1) % 8)*32 +: 32];
                a = {a[24:0], a[31:25]};
                n[w*32 +: 32] = a ^ k[w*32 +: 32] ^ 32'(r);
            end
            s = n;
        end
        return s ^ k;
    endfunction

    task automatic chk(input string name, input int id, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    int busy_cnt [4] = '{0, 0, 0, 0};

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (busy_v[i]) busy_cnt[i]++;
                if (done_v[i] || err_v[i]) begin
                    chk("done_err_exclusive", i, 256'(done_v[i] & err_v[i]), 256'(0));
                    chk("done_busy_exclusive", i, 256'(done_v[i] & busy_v[i]), 256'(0));
                    if (q.size() == 0) begin
                        chk("unexpected_event", i, 256'(1), 256'(0));
                    end else begin
                        e = q.pop_front();
                        chk("event_dut", i, 256'(i), 256'(e.id));
                        chk("event_kind_err", i, 256'(err_v[i]), 256'(e.is_err));
                        chk("event_cycle", i, 256'(cyc), 256'(e.cyc));
                        chk("signature", i, sig_v[i], e.sig);
                        chk("busy_cycles", i, 256'(busy_cnt[i]), 256'(e.is_err ? 0 : rnd_of(i)));
                    end
                    busy_cnt[i] = 0;
                end
                if (reset) busy_cnt[i] = 0;
            end
        end
    end

    task automatic op(input int id, input logic [255:0] h, input logic [255:0] k, input bit kv,
                      input logic [255:0] exp_sig);
        exp_t e;
        @(negedge clk);
        hash = h; key = k; key_valid = kv; start[id] = 1'b1;
        @(posedge clk); #1;
        e.id = id; e.is_err = !kv; e.sig = exp_sig; e.cyc = cyc + (kv ? rnd_of(id) : 0);
        q.push_back(e);
        @(negedge clk);
        start[id] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 0, 256'(q.size()), 256'(0));
        repeat (3) @(negedge clk);
    endtask

    localparam logic [255:0] S1  = {32'h80, 192'h0, 32'h80};
    localparam logic [255:0] S2  = {8{32'h0000_0001}};
    localparam logic [255:0] S3  = {8{32'h0000_0102}};
    localparam logic [255:0] H16 = 256'h0123456789abcdef_fedcba9876543210_deadbeefcafef00d_0011223344556677;
    localparam logic [255:0] K16 = 256'h8badf00d5eedc0de_0f1e2d3c4b5a6978_a5a5a5a55a5a5a5a_1357924680aceb0d;

    initial begin
        exp_t e;
        reset = 1'b1; hash = '0; key = '0; key_valid = 1'b0; start = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_signature", i, sig_v[i], '0);
            chk("reset_busy", i, 256'(busy_v[i]), 256'(0));
            chk("reset_done", i, 256'(done_v[i]), 256'(0));
            chk("reset_error", i, 256'(err_v[i]), 256'(0));
        end
        @(negedge clk);
        reset = 1'b0;

        op(1, '0, '0, 1'b1, S2);
        drain();
        op(1, '0, '0, 1'b0, S2);
        drain();

        // Held start with no key: one error pulse per sampled edge.
        @(negedge clk);
        key_valid = 1'b0; start[1] = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            e.id = 1; e.is_err = 1'b1; e.sig = S2; e.cyc = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        start[1] = 1'b0;
        drain();
        op(1, '0, '0, 1'b1, S2);
        drain();

        op(0, {224'h0, 32'h1}, '0, 1'b1, S1);
        drain();
        op(0, '0, {224'h0, 32'h1}, 1'b1, S1);
        drain();

        // Start held and inputs disturbed through a run, then accepted in the done cycle.
        @(negedge clk);
        hash = '0; key = '0; key_valid = 1'b1; start[2] = 1'b1;
        @(posedge clk); #1;
        e.id = 2; e.is_err = 1'b0; e.sig = S3; e.cyc = cyc + 3;
        q.push_back(e);
        @(negedge clk);
        hash = '1; key = '1; key_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        hash = '0; key = '0; key_valid = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("b2b_busy", 2, 256'(if3.sign_busy), 256'(1));
        e.id = 2; e.is_err = 1'b0; e.sig = S3; e.cyc = cyc + 3;
        q.push_back(e);
        @(negedge clk);
        start[2] = 1'b0;
        drain();

        op(3, H16, K16, 1'b1, ref_sign(H16, K16, 16));
        drain();

        // Reset lands during round 1; nothing is queued for the aborted run.
        @(negedge clk);
        hash = '0; key = '0; key_valid = 1'b1; start[3] = 1'b1;
        @(negedge clk);
        start[3] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_signature", 3, if16.signature, '0);
        chk("abort_busy", 3, 256'(if16.sign_busy), 256'(0));
        chk("abort_done", 3, 256'(if16.sign_done), 256'(0));
        chk("abort_error", 3, 256'(if16.sign_error), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        op(3, '0, '0, 1'b1, ref_sign('0, '0, 16));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/signature_sign.md
# signature_sign

Signing-side engine of the security agent. Produces a 256-bit keyed signature over a 256-bit hash using a fixed iterative ARX round function, one round per clock. It is the counterpart of the signature-verify path and feeds the attestation/SVID issuance logic. One operation at a time, with a start/busy/done handshake.

## Interface
Parameters:
- ROUNDS, 16: number of mixing rounds; legal range 1..255.
- ROT, 7: left-rotate amount applied in each round; legal range 1..31.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- hash  input  256  message hash; sampled only on an accepted start.
- key  input  256  signing key from the key store; sampled only on an accepted start.
- key_valid  input  1  key store holds a valid key.
- sign_start  input  1  request a signing operation; level-sampled each cycle.
- signature  output  256  result register; holds its value until the next completed operation.
- sign_busy  output  1  operation in progress.
- sign_done  output  1  one-cycle pulse; signature is valid in this cycle.
- sign_error  output  1  one-cycle pulse; start rejected because key_valid=0.

## Operation
- States: IDLE, RUN.
- Word view: state S (256 b) = words w0..w7, with w0 = S[31:0] and w7 = S[255:224]. Key words k0..k7 follow the same split.
- Accept in IDLE when sign_start=1 and key_valid=1:
  - latch key into key_q;
  - load S <= hash ^ key;
  - clear round counter r to 0;
  - go to RUN; sign_busy <= 1.
- Reject in IDLE when sign_start=1 and key_valid=0:
  - sign_error <= 1 for one cycle;
  - stay in IDLE; S and signature unchanged.
- RUN, one round per cycle. For every i simultaneously, using old words: w'i = rotl32((wi + w((i+1) mod 8)) mod 2^32, ROT) ^ kq_i ^ {24'b0, r}. Then r <= r+1.
- Round with r = ROUNDS-1 (final round):
  - signature <= S' ^ key_q, where S' is that round's output;
  - sign_done <= 1;
  - sign_busy <= 0;
  - return to IDLE.
- sign_start is ignored while in RUN. hash, key and key_valid changes during RUN have no effect, because key_q is used.
- The round counter is 8 bits. Additions wrap modulo 2^32 and carry is discarded.

## Timing
- Reset values: signature=0, sign_busy=0, sign_done=0, sign_error=0, state=IDLE, r=0, S=0, key_q=0.
- Start sampled high at edge E0 (accepted): sign_busy is high from after E0. Rounds 0..ROUNDS-1 execute at edges E1..E_ROUNDS. sign_done pulses and signature updates after edge E_ROUNDS. Latency from start edge to done is ROUNDS cycles. sign_busy is high for exactly ROUNDS cycles.
- The sign_done cycle is IDLE. A sign_start sampled in that cycle is accepted, giving back-to-back throughput of one operation per ROUNDS+1 cycles.
- sign_error pulses in the cycle after the rejected start edge. A held sign_start with key_valid=0 pulses sign_error every cycle.
- sign_done and sign_error are never high together. sign_done is never high while sign_busy is high.
- Reset asserted mid-RUN aborts at the next edge: all outputs go to reset values, no sign_done is produced, and the prior signature is cleared to 0.

## Test plan
- ROUNDS=2, key=0, hash=0, start for 1 cycle -> sign_done exactly 2 cycles after the start edge; signature = 0x00000001 in all eight words; sign_busy high for 2 cycles.
- ROUNDS=3, key=0, hash=0 -> signature = 0x00000102 in all eight words.
- ROUNDS=1, key=0, hash word w0=1, others 0 -> signature w0=0x80, w7=0x80, others 0.
- key_valid=0 with start pulse -> sign_error single pulse, sign_busy stays 0, signature unchanged. Then key_valid=1 with start -> normal completion.
- Start during RUN and key toggled mid-operation -> start ignored; result matches the undisturbed run; start asserted in the sign_done cycle is accepted (busy the next cycle).
- Reset asserted at round 1 of a 16-round operation -> all outputs 0 after the next edge; no sign_done; a new start then completes in 16 cycles.
